// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 byte constants, controller state encoding and byte classifiers.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } ps2_state_t;

    // Device status bytes carry no key information and are dropped when no prefix is pending.
    function automatic logic is_status(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_PAUSE);
    endfunction

    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_evt_slot.sv
// One-entry valid/ready event holding register with a sticky overflow flag.
module ps2_evt_slot
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_req,
    input  logic [7:0] load_code,
    input  logic       load_ext,
    input  logic       load_rel,
    input  logic       evt_ready,
    input  logic       ovf_clr,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       evt_valid,
    output logic       ovf
);

    logic accept;
    logic can_load;

    assign accept   = evt_valid && evt_ready;
    assign can_load = !evt_valid || accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_code    <= 8'h00;
            evt_ext     <= 1'b0;
            evt_release <= 1'b0;
            evt_valid   <= 1'b0;
        end else if (load_req && can_load) begin
            evt_code    <= load_code;
            evt_ext     <= load_ext;
            evt_release <= load_rel;
            evt_valid   <= 1'b1;
        end else if (accept) begin
            evt_valid   <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear must still be reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (load_req && !can_load) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 Set-2 scancode sequencer: prefix tracking, status filtering, prefix timeout.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | no prefix pending, waiting for a fresh code
// S_EXT     | E0 seen, waiting for code or F0
// S_BRK     | F0 seen, waiting for released code
// S_EXT_BRK | E0 F0 seen, waiting for released extended code
module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 120000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps2_data,
    input  logic       ps2_data_strb,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       kbd_err,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic            expire;
    logic            err_d;
    logic            emit;
    logic            emit_ext;
    logic            emit_rel;

    assign expire = (state_q != S_IDLE) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            kbd_err <= 1'b0;
        end else begin
            state_q <= state_d;
            kbd_err <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ps2_data_strb || (state_q == S_IDLE) || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        err_d    = 1'b0;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_rel = 1'b0;
        if (ps2_data_strb) begin
            case (state_q)
                S_IDLE: begin
                    if (ps2_data == PS2_EXT) begin
                        state_d = S_EXT;
                    end else if (ps2_data == PS2_BRK) begin
                        state_d = S_BRK;
                    end else if (is_err_byte(ps2_data)) begin
                        err_d = 1'b1;
                    end else if (!is_status(ps2_data)) begin
                        emit = 1'b1;
                    end
                end
                S_EXT: begin
                    if (ps2_data == PS2_BRK) begin
                        state_d = S_EXT_BRK;
                    end else if ((ps2_data == PS2_EXT) || is_err_byte(ps2_data)) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if ((ps2_data == PS2_EXT) || (ps2_data == PS2_BRK) || is_err_byte(ps2_data)) begin
                        err_d = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = (state_q == S_EXT_BRK);
                        emit_rel = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (expire) begin
            // Stalled prefix: abandon it so the next byte is decoded fresh.
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    ps2_evt_slot u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_req    (emit),
        .load_code   (ps2_data),
        .load_ext    (emit_ext),
        .load_rel    (emit_rel),
        .evt_ready   (evt_ready),
        .ovf_clr     (ovf_clr),
        .evt_code    (evt_code),
        .evt_ext     (evt_ext),
        .evt_release (evt_release),
        .evt_valid   (evt_valid),
        .ovf         (ovf)
    );

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Self-checking bench for ps2_scancode_ctrl: vector table, directed corner cases, random vs. model.
module tb_ps2_scancode_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ps2_data;
    logic       ps2_data_strb;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic       evt_valid;
    logic       evt_ready;
    logic       kbd_err;
    logic       ovf;
    logic       ovf_clr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ps2_scancode_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2_data      (ps2_data),
        .ps2_data_strb (ps2_data_strb),
        .evt_code      (evt_code),
        .evt_ext       (evt_ext),
        .evt_release   (evt_release),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .kbd_err       (kbd_err),
        .ovf           (ovf),
        .ovf_clr       (ovf_clr)
    );

    // Reference model: pending-prefix flags, wait time, and a one-deep output slot.
    logic       m_ext, m_brk;
    int         m_wait;
    logic       m_valid, m_xt, m_rel, m_err, m_ovf;
    logic [7:0] m_code;

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_wait = 0;
        m_valid = 0; m_xt = 0; m_rel = 0; m_err = 0; m_ovf = 0; m_code = 8'h00;
    endtask

    task automatic model_edge(input logic s, input logic [7:0] b, input logic r, input logic c);
        logic       em, ex, rl, drop;
        logic [7:0] ec;
        logic       pending;
        pending = m_ext || m_brk;
        em = 0; ex = 0; rl = 0; ec = b; drop = 0;
        m_err = 0;
        if (s) begin
            m_wait = 0;
            if (!pending) begin
                if (b == 8'hE0) m_ext = 1;
                else if (b == 8'hF0) m_brk = 1;
                else if (b == 8'h00 || b == 8'hFF) m_err = 1;
                else if (!(b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'hE1)) em = 1;
            end else if (m_brk) begin
                if (b == 8'hE0 || b == 8'hF0 || b == 8'h00 || b == 8'hFF) m_err = 1;
                else begin em = 1; ex = m_ext; rl = 1; end
                m_ext = 0; m_brk = 0;
            end else begin
                if (b == 8'hF0) m_brk = 1;
                else begin
                    if (b == 8'hE0 || b == 8'h00 || b == 8'hFF) m_err = 1;
                    else begin em = 1; ex = 1; end
                    m_ext = 0;
                end
            end
        end else if (pending) begin
            m_wait++;
            if (m_wait == TO) begin
                m_err = 1; m_ext = 0; m_brk = 0; m_wait = 0;
            end
        end
        if (em && (!m_valid || r)) begin
            m_valid = 1; m_code = ec; m_xt = ex; m_rel = rl;
        end else begin
            if (em) drop = 1;
            if (m_valid && r) m_valid = 0;
        end
        if (c) m_ovf = 0;
        if (drop) m_ovf = 1;
    endtask

    function automatic logic [12:0] dut_vec();
        return {evt_valid, evt_ext, evt_release, kbd_err, ovf, evt_code};
    endfunction

    function automatic logic [12:0] model_vec();
        return {m_valid, m_xt, m_rel, m_err, m_ovf, m_code};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {v,x,r,err,ovf,code}=%b_%h expected %b_%h @%0t",
                      name, act[12:8], act[7:0], exp[12:8], exp[7:0], $time);
    endtask

    task automatic step(input logic s, input logic [7:0] b, input logic r, input logic c);
        @(negedge clk);
        ps2_data_strb = s; ps2_data = b; evt_ready = r; ovf_clr = c;
        @(posedge clk);
        #1;
        model_edge(s, b, r, c);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; ps2_data_strb = 0; ps2_data = 8'h00; evt_ready = 0; ovf_clr = 0;
        @(posedge clk);
        #1;
        model_reset();
        check("reset", dut_vec(), 13'b0);
        @(negedge clk);
        rst = 0;
    endtask

    typedef struct {
        logic       s;
        logic [7:0] b;
        logic       r;
        logic       c;
        logic [12:0] exp; // {valid, ext, rel, err, ovf, code}
    } vec_t;

    vec_t tbl[21];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1);
    end

    initial begin
        // make, accept
        tbl[0]  = '{1, 8'h1C, 0, 0, {5'b10000, 8'h1C}};
        tbl[1]  = '{0, 8'h00, 1, 0, {5'b00000, 8'h1C}};
        // E0 F0 74
        tbl[2]  = '{1, 8'hE0, 1, 0, {5'b00000, 8'h1C}};
        tbl[3]  = '{1, 8'hF0, 1, 0, {5'b00000, 8'h1C}};
        tbl[4]  = '{1, 8'h74, 0, 0, {5'b11100, 8'h74}};
        tbl[5]  = '{0, 8'h00, 1, 0, {5'b01100, 8'h74}};
        // overflow, clear, accept
        tbl[6]  = '{1, 8'h1C, 0, 0, {5'b10000, 8'h1C}};
        tbl[7]  = '{1, 8'h32, 0, 0, {5'b10001, 8'h1C}};
        tbl[8]  = '{0, 8'h00, 0, 1, {5'b10000, 8'h1C}};
        tbl[9]  = '{0, 8'h00, 1, 0, {5'b00000, 8'h1C}};
        // status filtering and protocol errors
        tbl[10] = '{1, 8'hAA, 1, 0, {5'b00000, 8'h1C}};
        tbl[11] = '{1, 8'hFA, 1, 0, {5'b00000, 8'h1C}};
        tbl[12] = '{1, 8'hFE, 1, 0, {5'b00000, 8'h1C}};
        tbl[13] = '{1, 8'h00, 1, 0, {5'b00010, 8'h1C}};
        tbl[14] = '{1, 8'hF0, 1, 0, {5'b00000, 8'h1C}};
        tbl[15] = '{1, 8'hF0, 1, 0, {5'b00010, 8'h1C}};
        tbl[16] = '{1, 8'h1C, 0, 0, {5'b10000, 8'h1C}};
        tbl[17] = '{0, 8'h00, 1, 0, {5'b00000, 8'h1C}};
        // back-to-back accept and reload
        tbl[18] = '{1, 8'h21, 1, 0, {5'b10000, 8'h21}};
        tbl[19] = '{1, 8'h22, 1, 0, {5'b10000, 8'h22}};
        tbl[20] = '{0, 8'h00, 1, 0, {5'b00000, 8'h22}};

        rst = 1; ps2_data = 8'h00; ps2_data_strb = 0; evt_ready = 0; ovf_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].s, tbl[i].b, tbl[i].r, tbl[i].c);
            check($sformatf("tbl[%0d]", i), dut_vec(), tbl[i].exp);
        end

        // prefix timeout, then a fresh make
        step(1, 8'hF0, 1, 0);
        for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 1, 0);
        check("to_before", {4'b0, kbd_err}, 5'b0);
        step(0, 8'h00, 1, 0);
        check("to_err", {4'b0, kbd_err}, 5'b1);
        step(0, 8'h00, 1, 0);
        check("to_err_1cyc", {4'b0, kbd_err}, 5'b0);
        step(1, 8'h1C, 0, 0);
        check("to_make", dut_vec(), {5'b10000, 8'h1C});
        step(0, 8'h00, 1, 0);

        // strobe in the expiry cycle wins
        step(1, 8'hF0, 1, 0);
        for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 1, 0);
        step(1, 8'h2B, 0, 0);
        check("expiry_strobe", dut_vec(), {5'b10100, 8'h2B});
        step(0, 8'h00, 1, 0);
        check("expiry_noerr", {4'b0, kbd_err}, 5'b0);

        // reset discards held event and pending prefix
        step(1, 8'h1C, 0, 0);
        step(1, 8'h32, 0, 0);
        step(1, 8'hE0, 0, 0);
        do_reset();
        step(1, 8'h75, 0, 0);
        check("post_reset", dut_vec(), {5'b10000, 8'h75});
        step(0, 8'h00, 1, 0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic       s;
            logic [7:0] b;
            int         pick;
            s = ($urandom_range(0, 2) == 0);
            pick = $urandom_range(0, 11);
            case (pick)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4: begin
                    case ($urandom_range(0, 4))
                        0: b = 8'hAA; 1: b = 8'hFA; 2: b = 8'hEE; 3: b = 8'hFE; default: b = 8'hE1;
                    endcase
                end
                5:       b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                default: b = 8'($urandom_range(1, 254));
            endcase
            step(s, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 63) == 0) begin
                for (int j = 0; j < TO + 4; j++) step(0, 8'h00, 1'($urandom_range(0, 1)), 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
